// File: rtl/estimador_pkg.sv
// Shared types and default sizing for the multi-channel acquisition sequencer.
// The derived widths below describe the default configuration.
package estimador_pkg;

  localparam int unsigned N_DEF        = 32;
  localparam int unsigned M_DEF        = 12;
  localparam int unsigned CH_DEF       = 2;
  localparam int unsigned AVG_LOG2_DEF = 2;
  localparam int unsigned TIMEOUT_DEF  = 255;

  localparam int unsigned ACC_W = M_DEF + AVG_LOG2_DEF;
  localparam int unsigned CH_W  = $clog2(CH_DEF);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_DEF + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_EOC,
    NORM,
    WAIT_ACK
  } state_t;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/estimador_norm_fp.sv
// Combinational leading-one detector and left-justifying shifter that turns an
// M-bit average into exponent / mantissa form.
module estimador_norm_fp #(
  parameter int unsigned M = 12,
  parameter int unsigned N = 32
) (
  input  logic [M-1:0] avg,
  output logic [N-1:0] exp,
  output logic [N-1:0] mant
);

  localparam int unsigned PW = (M > 1) ? $clog2(M) : 1;

  logic [PW-1:0] msb;

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    msb = '0;
    for (int i = 0; i < M; i++) begin
      if (avg[i]) msb = PW'(i);
    end
  end

  always_comb begin
    exp  = '0;
    mant = '0;
    if (avg != '0) begin
      exp  = N'(msb);
      mant = N'(avg) << (N - 1 - int'(msb));
    end
  end

endmodule

// File: rtl/estimador_acq_seq.sv
// Multi-channel ADC acquisition sequencer: oversamples each channel, averages,
// normalises, and holds one result per channel until the estimator acknowledges it.
module estimador_acq_seq
  import estimador_pkg::*;
#(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned M        = M_DEF,
  parameter int unsigned CH       = CH_DEF,
  parameter int unsigned AVG_LOG2 = AVG_LOG2_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   EN,
  input  logic [M-1:0]           ADC_DATA,
  input  logic                   EOC,
  output logic                   START_ADC,
  output logic [$clog2(CH)-1:0]  CH_SEL,
  input  logic [CH-1:0]          ACK,
  output logic [CH-1:0]          VALID,
  output logic [CH*N-1:0]        EXP,
  output logic [CH*N-1:0]        MANTISSA,
  output logic                   ERR_TIMEOUT
);

  localparam int unsigned ACC_WIDTH = M + AVG_LOG2;
  localparam int unsigned CH_WIDTH  = $clog2(CH);
  localparam int unsigned TO_WIDTH  = width_of(TIMEOUT + 1);
  localparam int unsigned CNT_W     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned SAMPLES   = 1 << AVG_LOG2;

  localparam logic [CNT_W-1:0]    LAST_SMP = CNT_W'(SAMPLES - 1);
  localparam logic [TO_WIDTH-1:0] TO_LAST  = TO_WIDTH'(TIMEOUT - 1);
  localparam logic [CH_WIDTH-1:0] CH_LAST  = CH_WIDTH'(CH - 1);

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     smp_cnt;
  logic [TO_WIDTH-1:0]  to_cnt;

  logic [M-1:0]  avg_c;
  logic [N-1:0]  norm_exp_c;
  logic [N-1:0]  norm_mant_c;
  logic [CH-1:0] set_c;

  // Truncating average; the accumulator is wide enough that no sum overflows.
  assign avg_c = M'(acc >> AVG_LOG2);

  estimador_norm_fp #(
    .M (M),
    .N (N)
  ) u_norm (
    .avg  (avg_c),
    .exp  (norm_exp_c),
    .mant (norm_mant_c)
  );

  // One-hot result-ready strobe for the channel being normalised.
  always_comb begin
    set_c = '0;
    if (state == NORM) set_c[CH_SEL] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      START_ADC   <= 1'b0;
      CH_SEL      <= '0;
      VALID       <= '0;
      EXP         <= '0;
      MANTISSA    <= '0;
      ERR_TIMEOUT <= 1'b0;
      acc         <= '0;
      smp_cnt     <= '0;
      to_cnt      <= '0;
    end else begin
      START_ADC <= 1'b0;
      // A set in the same cycle as an ACK for that channel takes priority.
      VALID     <= (VALID & ~ACK) | set_c;

      case (state)
        IDLE: begin
          if (EN) begin
            state     <= START;
            START_ADC <= 1'b1;
          end
        end

        START: begin
          state  <= WAIT_EOC;
          to_cnt <= '0;
        end

        WAIT_EOC: begin
          if (EOC) begin
            acc <= acc + ACC_WIDTH'(ADC_DATA);
            if (smp_cnt != LAST_SMP) begin
              smp_cnt   <= smp_cnt + CNT_W'(1);
              state     <= START;
              START_ADC <= 1'b1;
            end else begin
              state <= NORM;
            end
          end else if (to_cnt == TO_LAST) begin
            // Retry the same sample; channel and partial sum are kept.
            ERR_TIMEOUT <= 1'b1;
            to_cnt      <= '0;
            state       <= START;
            START_ADC   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_WIDTH'(1);
          end
        end

        NORM: begin
          EXP[int'(CH_SEL)*N +: N]      <= norm_exp_c;
          MANTISSA[int'(CH_SEL)*N +: N] <= norm_mant_c;
          acc     <= '0;
          smp_cnt <= '0;
          if (CH_SEL != CH_LAST) begin
            CH_SEL    <= CH_SEL + CH_WIDTH'(1);
            state     <= START;
            START_ADC <= 1'b1;
          end else begin
            CH_SEL <= '0;
            state  <= WAIT_ACK;
          end
        end

        WAIT_ACK: begin
          if (VALID == '0) begin
            if (EN) begin
              state     <= START;
              START_ADC <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_estimador_acq_seq.sv
// Randomised self-checking bench for estimador_acq_seq with an ADC responder
// and an arithmetic reference for average and exponent/mantissa results.
module tb_estimador_acq_seq;

  localparam int unsigned N        = 32;
  localparam int unsigned M        = 12;
  localparam int unsigned CH       = 2;
  localparam int unsigned AVG_LOG2 = 2;
  localparam int unsigned TIMEOUT  = 255;
  localparam int unsigned SMP      = 1 << AVG_LOG2;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          EN  = 1'b0;
  logic          eoc_adc = 1'b0;
  logic          eoc_stray = 1'b0;
  logic [M-1:0]  adc_data = '0;
  logic [M-1:0]  stray_data = '0;
  logic          START_ADC;
  logic [0:0]    CH_SEL;
  logic [CH-1:0] ACK = '0;
  logic [CH-1:0] VALID;
  logic [CH*N-1:0] EXP;
  logic [CH*N-1:0] MANTISSA;
  logic          ERR_TIMEOUT;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int adc_dly = 0;
  int last_eoc_edge = 0;

  logic [M-1:0] adc_q[$];
  logic [N-1:0] ref_e [CH];
  logic [N-1:0] ref_m [CH];

  estimador_acq_seq #(
    .N(N), .M(M), .CH(CH), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .ADC_DATA   (eoc_stray ? stray_data : adc_data),
    .EOC        (eoc_adc | eoc_stray),
    .START_ADC  (START_ADC),
    .CH_SEL     (CH_SEL),
    .ACK        (ACK),
    .VALID      (VALID),
    .EXP        (EXP),
    .MANTISSA   (MANTISSA),
    .ERR_TIMEOUT(ERR_TIMEOUT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ADC model: answers each conversion request while it has samples queued.
  initial begin
    forever begin
      @(posedge CLK); #1;
      while (START_ADC && adc_q.size() > 0) begin
        repeat (1 + adc_dly) @(posedge CLK);
        #1;
        eoc_adc       = 1'b1;
        adc_data      = adc_q.pop_front();
        last_eoc_edge = cyc + 1;
        @(posedge CLK); #1;
        eoc_adc  = 1'b0;
        adc_data = M'($urandom);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [N-1:0] ref_exp(input int unsigned avg);
    if (avg == 0) return '0;
    return N'($clog2(avg + 1) - 1);
  endfunction

  function automatic logic [N-1:0] ref_mant(input int unsigned avg);
    logic [63:0] m;
    if (avg == 0) return '0;
    m = 64'(avg) << (N - 1 - ($clog2(avg + 1) - 1));
    return m[N-1:0];
  endfunction

  task automatic queue_ch(input int c, input logic [M-1:0] s [SMP]);
    int unsigned sum;
    sum = 0;
    for (int i = 0; i < SMP; i++) begin
      adc_q.push_back(s[i]);
      sum += 32'(s[i]);
    end
    ref_e[c] = ref_exp(sum / SMP);
    ref_m[c] = ref_mant(sum / SMP);
  endtask

  task automatic queue_rand_frame(input int kind);
    logic [M-1:0] s [SMP];
    for (int c = 0; c < CH; c++) begin
      for (int i = 0; i < SMP; i++)
        s[i] = (kind == 0) ? M'($urandom_range(0, (1 << M) - 1)) : M'($urandom_range(0, 7));
      queue_ch(c, s);
    end
  endtask

  task automatic check_results(input string tag);
    for (int c = 0; c < CH; c++) begin
      check($sformatf("%s_exp%0d", tag, c), 64'(EXP[c*N +: N]), 64'(ref_e[c]));
      check($sformatf("%s_mant%0d", tag, c), 64'(MANTISSA[c*N +: N]), 64'(ref_m[c]));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_start"}, 64'(START_ADC), 64'd0);
    check({tag, "_chsel"}, 64'(CH_SEL), 64'd0);
    check({tag, "_valid"}, 64'(VALID), 64'd0);
    check({tag, "_exp"}, 64'(EXP), 64'd0);
    check({tag, "_mant"}, 64'(MANTISSA), 64'd0);
    check({tag, "_err"}, 64'(ERR_TIMEOUT), 64'd0);
  endtask

  task automatic wait_valid(input logic [CH-1:0] want, input int budget, input string tag);
    int k;
    k = 0;
    while (k < budget && VALID !== want) begin
      @(posedge CLK); #1;
      k++;
    end
    check(tag, 64'(VALID), 64'(want));
  endtask

  task automatic wait_start(input int budget, input string tag);
    int k;
    k = 0;
    while (k < budget && START_ADC !== 1'b1) begin
      @(posedge CLK); #1;
      k++;
    end
    check(tag, 64'(START_ADC), 64'd1);
  endtask

  task automatic pulse_ack(input logic [CH-1:0] a);
    ACK = a;
    @(posedge CLK); #1;
    ACK = '0;
  endtask

  task automatic count_starts(input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge CLK); #1;
      if (START_ADC) n++;
    end
  endtask

  initial begin
    int n;
    int k;
    int s0;
    logic [M-1:0] s [SMP];

    // Reset state and first request after release
    repeat (3) @(posedge CLK);
    #1;
    check_zero("rst_init");
    s = '{12'h100, 12'h100, 12'h100, 12'h100};
    queue_ch(0, s);
    s = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    queue_ch(1, s);
    EN  = 1'b1;
    RST = 1'b1;
    @(posedge CLK); #1;
    check("first_start", 64'(START_ADC), 64'd1);
    check("first_chsel", 64'(CH_SEL), 64'd0);
    @(posedge CLK); #1;
    check("start_one_cycle", 64'(START_ADC), 64'd0);

    // Channel 0 result latency relative to the last accepted EOC
    k = 0;
    while (k < 100 && VALID[0] !== 1'b1) begin
      @(posedge CLK); #1;
      k++;
    end
    check("lat_ch0", 64'(cyc - last_eoc_edge), 64'd1);
    check("valid_ch0_only", 64'(VALID), 64'b01);
    check("f1_exp0_const", 64'(EXP[31:0]), 64'd8);
    check("f1_mant0_const", 64'(MANTISSA[31:0]), 64'h8000_0000);
    wait_valid(2'b11, 100, "f1_valid");
    check_results("f1");
    check("f1_exp1_const", 64'(EXP[63:32]), 64'd11);
    check("f1_mant1_const", 64'(MANTISSA[63:32]), 64'hFFF0_0000);

    // Backpressure: no ACK, stray EOCs must be ignored
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge CLK); #1;
      eoc_stray  = (i % 250 == 100);
      stray_data = M'($urandom);
      if (START_ADC) n++;
    end
    eoc_stray = 1'b0;
    @(posedge CLK); #1;
    check("bp_no_start", 64'(n), 64'd0);
    check("bp_valid_hold", 64'(VALID), 64'b11);
    check_results("bp_hold");

    s = '{12'h003, 12'h004, 12'h005, 12'h004};
    queue_ch(0, s);
    s = '{12'h000, 12'h000, 12'h000, 12'h000};
    queue_ch(1, s);
    pulse_ack(2'b01);
    check("bp_partial_valid", 64'(VALID), 64'b10);
    count_starts(20, n);
    check("bp_partial_no_start", 64'(n), 64'd0);

    // Final ACK releases the frame; ACK[1] stays high to collide with the set
    ACK = 2'b10;
    @(posedge CLK); #1;
    wait_start(2, "bp_restart");
    check("bp_restart_chsel", 64'(CH_SEL), 64'd0);
    wait_valid(2'b11, 200, "f2_set_wins");
    ACK = '0;
    check_results("f2");
    @(posedge CLK); #1;
    check("f2_valid_kept", 64'(VALID), 64'b11);

    // EOC timeout and retry of the same sample
    pulse_ack(2'b11);
    wait_start(3, "to_first_start");
    s0 = cyc;
    check("to_err_before", 64'(ERR_TIMEOUT), 64'd0);
    k = 0;
    while (k < 400) begin
      @(posedge CLK); #1;
      k++;
      if (cyc - s0 == 100) queue_rand_frame(0);
      if (START_ADC) break;
    end
    check("to_gap", 64'(cyc - s0), 64'(TIMEOUT + 1));
    check("to_err_set", 64'(ERR_TIMEOUT), 64'd1);
    check("to_same_chsel", 64'(CH_SEL), 64'd0);
    wait_valid(2'b11, 300, "f3_valid");
    check_results("f3");

    // EN dropped during channel 1: frame completes, then idle
    queue_rand_frame(1);
    adc_dly = $urandom_range(0, 3);
    pulse_ack(2'b11);
    k = 0;
    while (k < 200 && CH_SEL !== 1'b1) begin
      @(posedge CLK); #1;
      k++;
    end
    check("en_drop_on_ch1", 64'(CH_SEL), 64'd1);
    EN = 1'b0;
    wait_valid(2'b11, 300, "f4_valid");
    check_results("f4");
    check("err_sticky", 64'(ERR_TIMEOUT), 64'd1);
    pulse_ack(2'b11);
    count_starts(50, n);
    check("idle_no_start", 64'(n), 64'd0);
    check("idle_valid", 64'(VALID), 64'd0);
    queue_rand_frame(0);
    EN = 1'b1;
    wait_start(2, "en_resume");
    wait_valid(2'b11, 300, "f5_valid");
    check_results("f5");

    // Random frames with random ACK order and ADC latency
    for (int f = 0; f < 6; f++) begin
      queue_rand_frame(f % 2);
      adc_dly = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        pulse_ack(2'b01);
        check($sformatf("rnd%0d_part", f), 64'(VALID), 64'b10);
        for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
          @(posedge CLK); #1;
        end
        pulse_ack(2'b10);
      end else begin
        pulse_ack(2'b10);
        check($sformatf("rnd%0d_part", f), 64'(VALID), 64'b01);
        for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
          @(posedge CLK); #1;
        end
        pulse_ack(2'b01);
      end
      wait_valid(2'b11, 400, $sformatf("rnd%0d_valid", f));
      check_results($sformatf("rnd%0d", f));
    end

    // Asynchronous reset while waiting for EOC on channel 1
    adc_dly = 0;
    adc_q.delete();
    for (int i = 0; i < SMP; i++) s[i] = M'($urandom_range(1, (1 << M) - 1));
    queue_ch(0, s);
    pulse_ack(2'b11);
    k = 0;
    while (k < 200 && !(VALID === 2'b01 && CH_SEL === 1'b1)) begin
      @(posedge CLK); #1;
      k++;
    end
    check("mid_ch1_valid", 64'(VALID), 64'b01);
    repeat (3) @(posedge CLK);
    #3;
    RST = 1'b0;
    #1;
    check_zero("rst_mid");
    @(posedge CLK); #1;
    adc_q.delete();
    queue_rand_frame(0);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("post_rst_start", 64'(START_ADC), 64'd1);
    check("post_rst_chsel", 64'(CH_SEL), 64'd0);
    @(posedge CLK); #1;
    check("post_rst_one_cycle", 64'(START_ADC), 64'd0);
    wait_valid(2'b11, 300, "post_rst_valid");
    check_results("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
